exception_ctrl: RTL and testbench
=================================

Name: exception_ctrl

Overview:
- Parametrised, stateful successor to the combinational MEM-stage store/writeback suppression logic in the MIPS pipeline.
- Accepts N_SRC exception requests (PC fault, ALU overflow, ALU illegal, and others), masks and prioritises them, and gates MemWrite/Mem2Reg.
- Captures EPC and cause registers, then sequences pipeline flush, handler redirect and ERET return through a small FSM.
- Sits between the MEM stage and the PC-select logic.

Parameters:
- N_SRC, 4, number of exception sources; index 0 has highest priority.
- DATA_W, 32, PC/address width.
- CAUSE_W, 5, width of the cause code per source.
- HANDLER_ADDR, 32'h0000_0080, handler entry PC.
- CNT_W, 8, width of the saturating exception counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- exc_req  in  N_SRC  per-source exception request, valid for the current MEM-stage instruction.
- exc_code  in  N_SRC*CAUSE_W  cause code per source; source i occupies bits [i*CAUSE_W +: CAUSE_W].
- exc_pc  in  DATA_W  PC of the instruction in MEM.
- mem_write_in  in  1  MemWrite from control.
- mem_2_reg_in  in  1  Mem2Reg from control.
- eret  in  1  exception-return instruction in MEM.
- mask_we  in  1  mask register write enable.
- mask_wdata  in  N_SRC  new enable mask; 1 = source enabled.
- mem_write_out  out  1  gated MemWrite.
- mem_2_reg_out  out  1  gated Mem2Reg.
- flush  out  1  flush IF/ID/EX/MEM.
- redirect  out  1  PC override valid.
- redirect_pc  out  DATA_W  PC override value.
- epc  out  DATA_W  captured faulting PC.
- cause  out  CAUSE_W  captured cause code.
- cause_src  out  $clog2(N_SRC)  index of the captured source.
- in_handler  out  1  high while in FLUSH or HANDLER.
- double_fault  out  1  sticky flag.
- exc_count  out  CNT_W  saturating count of accepted exceptions.

Behaviour:
- Reset values: state=IDLE; epc=0; cause=0; cause_src=0; mask=all ones; double_fault=0; exc_count=0; flush=0; redirect=0; redirect_pc=0.
- Effective request: eff = exc_req & mask; any_eff = |eff.
- Gating (combinational, same cycle):
  - If any_eff or state==FLUSH: mem_write_out=0 and mem_2_reg_out=0. A defined 0 is required, never x.
  - Otherwise both outputs pass their inputs through.
- Priority: lowest set index of eff wins. Its code and index are the ones captured.
- FSM states: IDLE, FLUSH, HANDLER, RETURN.
  - IDLE & any_eff -> FLUSH. On the same edge capture epc<=exc_pc, cause, cause_src, and increment exc_count (saturating at all ones).
  - IDLE & eret & !any_eff -> stay in IDLE; eret is ignored (spurious).
  - FLUSH (exactly 1 cycle): flush=1, redirect=1, redirect_pc=HANDLER_ADDR. Next state is HANDLER unconditionally.
  - HANDLER & eret -> RETURN.
  - HANDLER & any_eff -> set double_fault (sticky, cleared only by rst). No capture; epc/cause are preserved. Gating still applies.
  - If eret and any_eff occur in the same HANDLER cycle, both take effect: RETURN is taken and double_fault is set.
  - RETURN (exactly 1 cycle): flush=1, redirect=1, redirect_pc=epc. Next state is IDLE.
  - Requests in RETURN are gated but not accepted; sources must hold the request into IDLE.
- Registered outputs: flush, redirect and redirect_pc are registered, so they assert the cycle after the accepting edge.
- Latency: request at cycle N -> gating at N, capture at edge N/N+1, flush and redirect during N+1.
- Mask write:
  - mask_we updates the mask at the edge; the new mask affects eff from the next cycle.
  - Writing the mask while in HANDLER is permitted.
- rst mid-operation returns the FSM to IDLE from any state. All registers take their reset values; no redirect is issued.
- in_handler = (state==FLUSH || state==HANDLER).

Decomposition:
- Shared package exc_pkg holds:
  - the state enum;
  - default cause codes (EXC_PC=5'd4, EXC_OVF=5'd12, EXC_ILL=5'd10);
  - the HANDLER_ADDR default.
- Sub-module prio_enc (parametrised N_SRC, lowest-index-first) outputs a one-hot grant, an index and a valid. It is instantiated once.

Test Plan:
- After rst, mem_write_in=1, mem_2_reg_in=1, no requests -> both outputs 1, state IDLE, exc_count=0, redirect=0.
- exc_req=4'b0110, exc_pc=32'h0040_0010, codes 12/10 on sources 1/2:
  - mem_write_out=0 in the same cycle;
  - next cycle flush=1, redirect_pc=32'h80, cause=12, cause_src=1, epc=32'h0040_0010, exc_count=1.
- In HANDLER assert eret -> one cycle of redirect=1 with redirect_pc=32'h0040_0010, then IDLE and in_handler=0.
- In HANDLER assert exc_req[0] -> double_fault=1 and epc unchanged. A subsequent eret still returns to the original epc. double_fault stays 1 until rst.
- mask_wdata=4'b1110 then exc_req=4'b0001 -> no gating (outputs follow inputs), no transition, exc_count unchanged.
- Assert rst during FLUSH -> next cycle state IDLE, flush=0, redirect=0, epc=0, mask=4'b1111.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the MEM-stage exception controller.
package exc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StHandler,
        StReturn
    } exc_state_e;

    // Default cause codes for the standard sources.
    localparam logic [4:0] EXC_PC  = 5'd4;
    localparam logic [4:0] EXC_OVF = 5'd12;
    localparam logic [4:0] EXC_ILL = 5'd10;

    localparam logic [31:0] HANDLER_ADDR_DEFAULT = 32'h0000_0080;

endpackage

// File: rtl/prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module prio_enc #(
    parameter int unsigned N_SRC = 4,
    localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    output logic [N_SRC-1:0] gnt,
    output logic [IdxW-1:0]  idx,
    output logic             valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = |req;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception controller: masks and prioritises requests, gates
// MemWrite/Mem2Reg, captures EPC/cause and sequences flush, handler entry
// and ERET return.
module exception_ctrl
    import exc_pkg::*;
#(
    parameter int unsigned N_SRC   = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CAUSE_W = 5,
    parameter logic [DATA_W-1:0] HANDLER_ADDR = DATA_W'(HANDLER_ADDR_DEFAULT),
    parameter int unsigned CNT_W   = 8,
    localparam int unsigned IdxW   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         exc_req,
    input  logic [N_SRC*CAUSE_W-1:0] exc_code,
    input  logic [DATA_W-1:0]        exc_pc,
    input  logic                     mem_write_in,
    input  logic                     mem_2_reg_in,
    input  logic                     eret,
    input  logic                     mask_we,
    input  logic [N_SRC-1:0]         mask_wdata,
    output logic                     mem_write_out,
    output logic                     mem_2_reg_out,
    output logic                     flush,
    output logic                     redirect,
    output logic [DATA_W-1:0]        redirect_pc,
    output logic [DATA_W-1:0]        epc,
    output logic [CAUSE_W-1:0]       cause,
    output logic [IdxW-1:0]          cause_src,
    output logic                     in_handler,
    output logic                     double_fault,
    output logic [CNT_W-1:0]         exc_count
);

    exc_state_e         state_q, state_d;
    logic [N_SRC-1:0]   mask_q;
    logic [N_SRC-1:0]   eff;
    logic [N_SRC-1:0]   eff_gnt;
    logic [IdxW-1:0]    eff_idx;
    logic               any_eff;
    logic [CAUSE_W-1:0] cause_sel;
    logic               accept;
    logic               dbl_set;
    logic [DATA_W-1:0]  epc_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [IdxW-1:0]    cause_src_q;
    logic               dbl_q;
    logic [CNT_W-1:0]   exc_count_q;
    logic               redir_q;
    logic [DATA_W-1:0]  redirect_pc_q;

    assign eff = exc_req & mask_q;

    prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .req   (eff),
        .gnt   (eff_gnt),
        .idx   (eff_idx),
        .valid (any_eff)
    );

    // Select the winning source's cause code with an AND-OR over the grant.
    always_comb begin
        cause_sel = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (eff_gnt[i]) begin
                cause_sel = cause_sel | exc_code[i*CAUSE_W +: CAUSE_W];
            end
        end
    end

    // Next-state logic plus capture and double-fault strobes.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        dbl_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_eff) begin
                    state_d = StFlush;
                    accept  = 1'b1;
                end
            end
            StFlush:  state_d = StHandler;
            StHandler: begin
                if (eret) begin
                    state_d = StReturn;
                end
                if (any_eff) begin
                    dbl_set = 1'b1;
                end
            end
            StReturn: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State, capture registers and the registered redirect outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            mask_q        <= '1;
            epc_q         <= '0;
            cause_q       <= '0;
            cause_src_q   <= '0;
            dbl_q         <= 1'b0;
            exc_count_q   <= '0;
            redir_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                epc_q       <= exc_pc;
                cause_q     <= cause_sel;
                cause_src_q <= eff_idx;
                if (exc_count_q != '1) begin
                    exc_count_q <= exc_count_q + 1'b1;
                end
            end
            if (dbl_set) begin
                dbl_q <= 1'b1;
            end
            if (mask_we) begin
                mask_q <= mask_wdata;
            end
            // epc_q cannot change while heading into RETURN, so it is safe here.
            redir_q <= (state_d == StFlush) || (state_d == StReturn);
            if (state_d == StFlush) begin
                redirect_pc_q <= HANDLER_ADDR;
            end else if (state_d == StReturn) begin
                redirect_pc_q <= epc_q;
            end else begin
                redirect_pc_q <= '0;
            end
        end
    end

    // Store/writeback suppression is combinational so it hits the faulting instruction.
    always_comb begin
        if (any_eff || (state_q == StFlush)) begin
            mem_write_out = 1'b0;
            mem_2_reg_out = 1'b0;
        end else begin
            mem_write_out = mem_write_in;
            mem_2_reg_out = mem_2_reg_in;
        end
    end

    assign flush        = redir_q;
    assign redirect     = redir_q;
    assign redirect_pc  = redirect_pc_q;
    assign epc          = epc_q;
    assign cause        = cause_q;
    assign cause_src    = cause_src_q;
    assign in_handler   = (state_q == StFlush) || (state_q == StHandler);
    assign double_fault = dbl_q;
    assign exc_count    = exc_count_q;

endmodule

// File: tb/tb_exception_ctrl.sv
// Randomised bench for exception_ctrl against a behavioural model.
module tb_exception_ctrl;
    import exc_pkg::*;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  exc_req;
    logic [19:0] exc_code;
    logic [31:0] exc_pc;
    logic        mem_write_in, mem_2_reg_in, eret, mask_we;
    logic [3:0]  mask_wdata;
    logic        mem_write_out, mem_2_reg_out, flush, redirect, in_handler, double_fault;
    logic [31:0] redirect_pc, epc;
    logic [4:0]  cause;
    logic [1:0]  cause_src;
    logic [7:0]  exc_count;

    exception_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .exc_pc        (exc_pc),
        .mem_write_in  (mem_write_in),
        .mem_2_reg_in  (mem_2_reg_in),
        .eret          (eret),
        .mask_we       (mask_we),
        .mask_wdata    (mask_wdata),
        .mem_write_out (mem_write_out),
        .mem_2_reg_out (mem_2_reg_out),
        .flush         (flush),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .epc           (epc),
        .cause         (cause),
        .cause_src     (cause_src),
        .in_handler    (in_handler),
        .double_fault  (double_fault),
        .exc_count     (exc_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: phases described by name, not by any encoding of the design.
    bit          m_in_flush, m_in_handler, m_in_return;
    logic [31:0] m_epc;
    logic [4:0]  m_cause;
    int          m_src;
    logic [3:0]  m_mask;
    bit          m_dbl;
    int          m_cnt;

    task automatic model_reset();
        m_in_flush = 0; m_in_handler = 0; m_in_return = 0;
        m_epc = 0; m_cause = 0; m_src = 0; m_mask = 4'hf; m_dbl = 0; m_cnt = 0;
    endtask

    function automatic int lowest_set(input logic [3:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Apply one clock edge to the model using the inputs present at that edge.
    task automatic model_edge();
        logic [3:0] e;
        int w;
        if (rst) begin
            model_reset();
            return;
        end
        e = exc_req & m_mask;
        w = lowest_set(e);
        if (m_in_flush) begin
            m_in_flush = 0; m_in_handler = 1;
        end else if (m_in_handler) begin
            if (w >= 0) m_dbl = 1;
            if (eret) begin
                m_in_handler = 0; m_in_return = 1;
            end
        end else if (m_in_return) begin
            m_in_return = 0;
        end else if (w >= 0) begin
            m_in_flush = 1;
            m_epc   = exc_pc;
            m_cause = exc_code[w*5 +: 5];
            m_src   = w;
            if (m_cnt < 255) m_cnt++;
        end
        if (mask_we) m_mask = mask_wdata;
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic cycle();
        bit gate, redir;
        #2;
        gate  = ((exc_req & m_mask) != 0) || m_in_flush;
        redir = m_in_flush || m_in_return;
        check_eq("mem_write_out", mem_write_out, gate ? 1'b0 : mem_write_in);
        check_eq("mem_2_reg_out", mem_2_reg_out, gate ? 1'b0 : mem_2_reg_in);
        check_eq("flush", flush, redir);
        check_eq("redirect", redirect, redir);
        if (redir) check_eq("redirect_pc", redirect_pc, m_in_flush ? 32'h80 : m_epc);
        check_eq("epc", epc, m_epc);
        check_eq("cause", cause, m_cause);
        check_eq("cause_src", cause_src, m_src);
        check_eq("in_handler", in_handler, m_in_flush || m_in_handler);
        check_eq("double_fault", double_fault, m_dbl);
        check_eq("exc_count", exc_count, m_cnt);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; exc_req = 0; eret = 0; mask_we = 0; mask_wdata = 4'hf;
        mem_write_in = 1; mem_2_reg_in = 1;
    endtask

    initial begin
        idle_inputs();
        exc_code = {5'd3, EXC_ILL, EXC_OVF, EXC_PC};
        exc_pc   = 32'h0;
        rst      = 1;
        @(posedge clk);
        model_reset();
        #1;
        rst = 0;

        // Reset state with pass-through.
        cycle();
        check_eq("rst_redirect_pc", redirect_pc, 32'h0);
        check_eq("rst_count", exc_count, 8'd0);

        // Two sources, source 1 wins.
        exc_req = 4'b0110; exc_pc = 32'h0040_0010;
        cycle();
        exc_req = 0;
        check_eq("tp_cause", cause, EXC_OVF);
        check_eq("tp_src", cause_src, 2'd1);
        check_eq("tp_rpc", redirect_pc, 32'h80);
        cycle();
        cycle();

        // Double fault in handler, then return to the original EPC.
        exc_req = 4'b0001; exc_pc = 32'h1234_0000;
        cycle();
        exc_req = 0;
        check_eq("tp_dbl", double_fault, 1'b1);
        check_eq("tp_epc_kept", epc, 32'h0040_0010);
        eret = 1;
        cycle();
        eret = 0;
        check_eq("tp_ret_pc", redirect_pc, 32'h0040_0010);
        cycle();
        cycle();
        check_eq("tp_idle", in_handler, 1'b0);

        // Spurious eret in IDLE.
        eret = 1;
        cycle();
        eret = 0;

        // Masked source is ignored.
        mask_we = 1; mask_wdata = 4'b1110;
        cycle();
        mask_we = 0; exc_req = 4'b0001; mem_write_in = 1; mem_2_reg_in = 0;
        cycle();
        cycle();
        check_eq("tp_mask_cnt", exc_count, 8'd1);

        // Reset during FLUSH.
        exc_req = 4'b0010; mem_2_reg_in = 1;
        cycle();
        exc_req = 0; rst = 1;
        cycle();
        rst = 0;
        check_eq("tp_rst_flush", flush, 1'b0);
        check_eq("tp_rst_epc", epc, 32'h0);
        exc_req = 4'b0001;
        cycle();
        exc_req = 0;
        check_eq("tp_rst_mask", cause_src, 2'd0);
        cycle();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            rst          = ($urandom_range(0, 99) == 0);
            exc_req      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            exc_code     = 20'($urandom);
            exc_pc       = $urandom;
            mem_write_in = 1'($urandom);
            mem_2_reg_in = 1'($urandom);
            eret         = ($urandom_range(0, 3) == 0);
            mask_we      = ($urandom_range(0, 15) == 0);
            mask_wdata   = 4'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
